// File: rtl/strip_sched.sv
// Symbol scheduler ahead of the 4-lane striper: frames packets with STP/END/EDB, pads to lane 3, idles, and inserts SKP ordered sets.
// Two register stages, so a byte accepted at edge n is on OUT_D after edge n+1. IN_READY is high only while packet data is being taken.
module strip_sched #(
  parameter int SKP_INTERVAL = 1180,
  parameter int SKP_LEN      = 3,
  parameter int MAX_PKT      = 1024
) (
  input  logic       CLK,
  input  logic       RESET_L,
  input  logic [7:0] IN_DATA,
  input  logic       IN_VALID,
  input  logic       IN_SOP,
  input  logic       IN_EOP,
  output logic       IN_READY,
  output logic [7:0] OUT_D,
  output logic       OUT_DK,
  output logic       OUT_VALID,
  output logic [1:0] LANE_IDX,
  output logic       SKP_ACT,
  output logic       ERR
);

  localparam logic [7:0] K_STP = 8'hFB;
  localparam logic [7:0] K_END = 8'hFD;
  localparam logic [7:0] K_EDB = 8'hFE;
  localparam logic [7:0] K_COM = 8'hBC;
  localparam logic [7:0] K_SKP = 8'h1C;
  localparam logic [7:0] K_IDL = 8'h7C;
  localparam logic [7:0] K_PAD = 8'hF7;

  localparam int TW = $clog2(SKP_INTERVAL);
  localparam int PW = $clog2(MAX_PKT + 1);
  localparam int CW = (PW > 5) ? PW : 5;
  localparam logic [TW-1:0] TMAX  = TW'(SKP_INTERVAL - 1);
  localparam logic [CW-1:0] PLAST = CW'(MAX_PKT - 1);
  localparam logic [CW-1:0] SLAST = CW'(4 * SKP_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_STP, S_DATA, S_TERM, S_PAD, S_COM, S_SKP
  } state_t;

  state_t        state;
  logic [1:0]    gen_lane;
  logic [CW-1:0] cnt;
  logic [TW-1:0] timer;
  logic          skp_due;
  logic [7:0]    term_d;
  logic [7:0]    st_d;
  logic          st_k;
  logic [1:0]    st_lane;
  logic          st_skp;
  logic          st_err;

  // The st_* stage holds the symbol chosen this cycle; gen_lane is its lane,
  // so a decision made while gen_lane==3 places the next symbol on lane 0.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state     <= S_IDLE;
      gen_lane  <= 2'd1;
      cnt       <= '0;
      timer     <= '0;
      skp_due   <= 1'b0;
      term_d    <= K_END;
      st_d      <= K_IDL;
      st_k      <= 1'b1;
      st_lane   <= 2'd0;
      st_skp    <= 1'b0;
      st_err    <= 1'b0;
      IN_READY  <= 1'b0;
      OUT_D     <= 8'h00;
      OUT_DK    <= 1'b0;
      OUT_VALID <= 1'b0;
      LANE_IDX  <= 2'd0;
      SKP_ACT   <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      OUT_D     <= st_d;
      OUT_DK    <= st_k;
      OUT_VALID <= 1'b1;
      LANE_IDX  <= st_lane;
      SKP_ACT   <= st_skp;
      ERR       <= st_err;

      st_lane  <= gen_lane;
      gen_lane <= gen_lane + 2'd1;
      st_k     <= 1'b1;
      st_skp   <= 1'b0;
      st_err   <= 1'b0;
      IN_READY <= 1'b0;

      timer <= (timer == TMAX) ? '0 : timer + TW'(1);
      if (timer == TMAX) skp_due <= 1'b1;

      case (state)
        S_IDLE: begin
          st_d <= K_IDL;
          if (gen_lane == 2'd3) begin
            if (skp_due) begin
              state   <= S_COM;
              timer   <= '0;
              skp_due <= 1'b0;
              cnt     <= '0;
            end else if (IN_VALID && IN_SOP) begin
              state <= S_STP;
            end
          end
        end
        S_STP: begin
          st_d     <= K_STP;
          cnt      <= '0;
          IN_READY <= 1'b1;
          state    <= S_DATA;
        end
        S_DATA: begin
          if (IN_VALID) begin
            st_d <= IN_DATA;
            st_k <= 1'b0;
            cnt  <= cnt + CW'(1);
            if (IN_EOP) begin
              term_d <= K_END;
              state  <= S_TERM;
            end else if (cnt == PLAST) begin
              term_d <= K_EDB;
              state  <= S_TERM;
            end else begin
              IN_READY <= 1'b1;
            end
          end else begin
            // Underrun: the missing byte's slot carries EDB directly.
            st_d   <= K_EDB;
            st_err <= 1'b1;
            state  <= (gen_lane == 2'd3) ? S_IDLE : S_PAD;
          end
        end
        S_TERM: begin
          st_d   <= term_d;
          st_err <= (term_d == K_EDB);
          state  <= (gen_lane == 2'd3) ? S_IDLE : S_PAD;
        end
        S_PAD: begin
          st_d <= K_PAD;
          if (gen_lane == 2'd3) state <= S_IDLE;
        end
        S_COM: begin
          st_d   <= K_COM;
          st_skp <= 1'b1;
          if (cnt == CW'(3)) begin
            cnt   <= '0;
            state <= S_SKP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_SKP: begin
          st_d   <= K_SKP;
          st_skp <= 1'b1;
          cnt    <= cnt + CW'(1);
          if (cnt == SLAST) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_strip_sched.sv
// Scoreboard bench for strip_sched: lane-set level reference model feeds an expected-symbol queue.
module tb_strip_sched;

  localparam int SKP_INTERVAL = 24;
  localparam int SKP_LEN      = 3;
  localparam int MAX_PKT      = 12;

  localparam logic [7:0] K_STP = 8'hFB;
  localparam logic [7:0] K_END = 8'hFD;
  localparam logic [7:0] K_EDB = 8'hFE;
  localparam logic [7:0] K_COM = 8'hBC;
  localparam logic [7:0] K_SKP = 8'h1C;
  localparam logic [7:0] K_IDL = 8'h7C;
  localparam logic [7:0] K_PAD = 8'hF7;

  logic       CLK = 1'b0;
  logic       RESET_L;
  logic [7:0] IN_DATA;
  logic       IN_VALID, IN_SOP, IN_EOP;
  logic       IN_READY;
  logic [7:0] OUT_D;
  logic       OUT_DK, OUT_VALID, SKP_ACT, ERR;
  logic [1:0] LANE_IDX;

  strip_sched #(.SKP_INTERVAL(SKP_INTERVAL), .SKP_LEN(SKP_LEN), .MAX_PKT(MAX_PKT)) dut (
    .CLK(CLK), .RESET_L(RESET_L), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID),
    .IN_SOP(IN_SOP), .IN_EOP(IN_EOP), .IN_READY(IN_READY), .OUT_D(OUT_D),
    .OUT_DK(OUT_DK), .OUT_VALID(OUT_VALID), .LANE_IDX(LANE_IDX),
    .SKP_ACT(SKP_ACT), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0] d;
    logic       k;
    logic       skp;
    logic       err;
  } sym_t;

  sym_t       expq[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         mon_k = 0;
  bit         mon_en = 1'b0;
  int         cyc = 0;
  int         t0 = 0;
  logic [7:0] pbuf [0:MAX_PKT+7];

  // Output monitor: every valid symbol must match the next queued expectation.
  always @(negedge CLK) begin
    if (mon_en && RESET_L) begin
      sym_t e;
      vectors++;
      if (OUT_VALID !== 1'b1 || expq.size() == 0) begin
        miscompares++;
        $display("FAIL out_stream k=%0d valid=%b queued=%0d d=%h", mon_k, OUT_VALID, expq.size(), OUT_D);
      end else begin
        e = expq.pop_front();
        if ({OUT_D, OUT_DK, SKP_ACT, ERR} !== {e.d, e.k, e.skp, e.err} || LANE_IDX !== mon_k[1:0]) begin
          miscompares++;
          $display("FAIL symbol k=%0d got d=%h dk=%b skp=%b err=%b lane=%0d, expected d=%h dk=%b skp=%b err=%b lane=%0d",
                   mon_k, OUT_D, OUT_DK, SKP_ACT, ERR, LANE_IDX, e.d, e.k, e.skp, e.err, mon_k % 4);
        end
      end
      mon_k++;
    end
  end

  function automatic void push(input logic [7:0] d, input bit k, input bit s, input bit e);
    sym_t x;
    x.d = d; x.k = k; x.skp = s; x.err = e;
    expq.push_back(x);
  endfunction

  // One generated cycle: queue its symbol, drive inputs, check IN_READY, advance.
  task automatic emit(input logic [7:0] d, input bit k, input bit s, input bit e,
                      input bit v, input bit sop, input bit eop, input logic [7:0] dat, input bit rdy);
    push(d, k, s, e);
    IN_VALID = v; IN_SOP = sop; IN_EOP = eop; IN_DATA = dat;
    vectors++;
    if (IN_READY !== rdy) begin
      miscompares++;
      $display("FAIL in_ready cyc=%0d got %b expected %b", cyc, IN_READY, rdy);
    end
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic check_reset(input string name);
    vectors++;
    if ({OUT_D, OUT_DK, OUT_VALID, LANE_IDX, IN_READY, SKP_ACT, ERR} !== 15'b0) begin
      miscompares++;
      $display("FAIL %s got d=%h dk=%b v=%b lane=%0d rdy=%b skp=%b err=%b expected all zero",
               name, OUT_D, OUT_DK, OUT_VALID, LANE_IDX, IN_READY, SKP_ACT, ERR);
    end
  endtask

  task automatic release_reset();
    IN_VALID = 0; IN_SOP = 0; IN_EOP = 0; IN_DATA = 0;
    expq.delete();
    mon_k = 0; cyc = 0; t0 = 0;
    @(negedge CLK);
    RESET_L = 1'b1;
    push(K_IDL, 1, 0, 0);  // reset content of the symbol stage
    push(K_IDL, 1, 0, 0);  // cycle 0, lane 1
    @(posedge CLK);
    #1;
    cyc = 1;
    mon_en = 1'b1;
    emit(K_IDL, 1, 0, 0, 0, 0, 0, 8'h00, 0);
    emit(K_IDL, 1, 0, 0, 0, 0, 0, 8'h00, 0);
  endtask

  // One IDL lane set; on its last slot either a SKP set or the presented packet starts.
  task automatic idle_set(input bit pres, input logic [7:0] b0, input bit e0, output bit started);
    bit due;
    started = 1'b0;
    for (int i = 0; i < 3; i++) emit(K_IDL, 1, 0, 0, pres, pres, e0, b0, 0);
    due = (cyc - t0 >= SKP_INTERVAL);
    emit(K_IDL, 1, 0, 0, pres, pres, e0, b0, 0);
    if (due) begin
      t0 = cyc;
      for (int i = 0; i < 4; i++) emit(K_COM, 1, 1, 0, pres, pres, e0, b0, 0);
      for (int i = 0; i < 4 * SKP_LEN; i++) emit(K_SKP, 1, 1, 0, pres, pres, e0, b0, 0);
    end else begin
      started = pres;
    end
  endtask

  task automatic send(input int len, input int und, input int gap);
    bit st;
    int n;
    for (int g = 0; g < gap; g++) idle_set(0, 8'h00, 0, st);
    st = 1'b0;
    for (int t = 0; t < 8 && !st; t++) idle_set(1, pbuf[0], len == 1, st);
    if (!st) begin
      miscompares++;
      $display("FAIL pkt_start model never started packet len=%0d", len);
    end else begin
      emit(K_STP, 1, 0, 0, 1, 1, len == 1, pbuf[0], 0);
      n = 1;
      for (int i = 0; i < MAX_PKT + 4; i++) begin
        if (i == und) begin
          emit(K_EDB, 1, 0, 1, 0, 0, 0, 8'h00, 1);
          n++;
          break;
        end
        emit(pbuf[i], 0, 0, 0, 1, i == 0, i == len - 1, pbuf[i], 1);
        n++;
        if (i == len - 1) begin
          emit(K_END, 1, 0, 0, 0, 0, 0, 8'h00, 0);
          n++;
          break;
        end
        if (i == MAX_PKT - 1) begin
          emit(K_EDB, 1, 0, 1, 0, 0, 0, 8'h00, 0);
          n++;
          break;
        end
      end
      while (n % 4 != 0) begin
        emit(K_PAD, 1, 0, 0, 0, 0, 0, 8'h00, 0);
        n++;
      end
    end
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (expq.size() != 0 && i < 40) begin
      @(posedge CLK);
      i++;
    end
    mon_en = 1'b0;
    if (expq.size() != 0) begin
      miscompares++;
      $display("FAIL drain %0d expected symbols never observed", expq.size());
    end
  endtask

  initial begin
    int len, und;
    bit st;
    RESET_L = 1'b0;
    IN_VALID = 0; IN_SOP = 0; IN_EOP = 0; IN_DATA = 0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_reset("reset_state");
    release_reset();

    pbuf[0] = 8'hA1; pbuf[1] = 8'hA2; pbuf[2] = 8'hA3;
    send(3, -1, 0);
    for (int i = 0; i < 6; i++) pbuf[i] = 8'(8'h10 + i);
    send(6, -1, 1);
    for (int i = 0; i < 5; i++) pbuf[i] = 8'(8'h30 + i);
    send(5, 2, 0);
    for (int i = 0; i < MAX_PKT + 3; i++) pbuf[i] = 8'(8'h50 + i);
    send(MAX_PKT + 3, -1, 0);
    send(MAX_PKT, -1, 0);
    send(1, -1, 0);
    send(4, 0, 0);
    for (int g = 0; g < 6; g++) idle_set(0, 8'h00, 0, st);

    for (int p = 0; p < 60; p++) begin
      len = int'($urandom_range(1, MAX_PKT + 3));
      und = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      for (int i = 0; i < len; i++) pbuf[i] = 8'($urandom);
      send(len, und, int'($urandom_range(0, 2)));
    end

    // Reset in the middle of a packet.
    for (int i = 0; i < 8; i++) pbuf[i] = 8'(8'hC0 + i);
    st = 1'b0;
    for (int t = 0; t < 8 && !st; t++) idle_set(1, pbuf[0], 0, st);
    emit(K_STP, 1, 0, 0, 1, 1, 0, pbuf[0], 0);
    emit(pbuf[0], 0, 0, 0, 1, 1, 0, pbuf[0], 1);
    emit(pbuf[1], 0, 0, 0, 1, 0, 0, pbuf[1], 1);
    mon_en = 1'b0;
    RESET_L = 1'b0;
    #1;
    check_reset("reset_mid_packet");
    IN_VALID = 0; IN_SOP = 0; IN_EOP = 0;
    repeat (2) @(posedge CLK);
    #1;
    check_reset("reset_held");
    release_reset();
    for (int i = 0; i < 3; i++) pbuf[i] = 8'(8'hE0 + i);
    send(3, -1, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
